// File: rtl/gate_bist_pkg.sv
// Shared constants for the basic-gate self-test engine: reference truth tables
// for the two-input gate library and the checker state encoding.
package gate_bist_pkg;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  // Settle counter is wide enough for SETTLE_CYCLES up to 15.
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_e;

endpackage

// File: rtl/gate_bist_vector_counter.sv
// Stimulus/settle counter pair for the gate self-test: walks every input
// vector, holding each for SETTLE_CYCLES+1 clocks, and flags the sample edge.
module bist_vector_counter
  import gate_bist_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  output logic [N_IN-1:0] stim,
  output logic            last_vec,
  output logic            sample
);

  logic [N_IN-1:0]     stim_q, stim_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;

  assign stim     = stim_q;
  assign last_vec = (stim_q == {N_IN{1'b1}});
  assign sample   = en && (settle_q == SETTLE_W'(SETTLE_CYCLES));

  // clr wins over counting so the final sample edge can park stim at zero.
  always_comb begin
    stim_d   = stim_q;
    settle_d = settle_q;
    if (clr) begin
      stim_d   = '0;
      settle_d = '0;
    end else if (en) begin
      if (sample) begin
        settle_d = '0;
        if (!last_vec) begin
          stim_d = stim_q + N_IN'(1);
        end
      end else begin
        settle_d = settle_q + SETTLE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim_q   <= '0;
      settle_q <= '0;
    end else begin
      stim_q   <= stim_d;
      settle_q <= settle_d;
    end
  end

endmodule

// File: rtl/gate_bist_checker.sv
// On-chip self-test for an N-input combinational gate: sequences all input
// vectors, compares the sampled output with TRUTH_TABLE and reports the result.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int                      N_IN          = 2,
  parameter logic [(1<<N_IN)-1:0]    TRUTH_TABLE   = TT_AND,
  parameter int                      SETTLE_CYCLES = 1,
  parameter int                      ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  stim,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [N_IN-1:0]  first_fail
);

  bist_state_e      state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_seen_q, fail_seen_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [N_IN-1:0]  first_fail_q, first_fail_d;

  logic accept;
  logic cnt_clr;
  logic cnt_en;
  logic last_vec;
  logic sample;
  logic expected_y;
  logic mismatch;

  assign accept  = (state_q == IDLE) && start;
  assign cnt_en  = (state_q == RUN);
  assign cnt_clr = accept || (sample && last_vec);

  bist_vector_counter #(
    .N_IN          (N_IN),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_vec_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .stim     (stim),
    .last_vec (last_vec),
    .sample   (sample)
  );

  // Case inequality makes an X/Z gate output count as a failure in simulation;
  // hardware sees an ordinary compare.
  assign expected_y = TRUTH_TABLE[stim];
  assign mismatch   = (dut_y !== expected_y);

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_seen_d  = fail_seen_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          fail_seen_d  = 1'b0;
          err_count_d  = '0;
          first_fail_d = '0;
        end
      end
      RUN: begin
        if (sample) begin
          if (mismatch) begin
            if (err_count_q != {ERR_W{1'b1}}) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
            if (!fail_seen_q) begin
              fail_seen_d  = 1'b1;
              first_fail_d = stim;
            end
          end
          if (last_vec) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_seen_q  <= 1'b0;
      err_count_q  <= '0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_seen_q  <= fail_seen_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench for gate_bist_checker: three checker instances (AND, wrong
// OR table, XOR with zero settle) exercised one at a time through a selector.
module tb_gate_bist_checker;
  import gate_bist_pkg::*;

  logic clk;
  logic rst;
  logic start;
  int   sel;
  int   y_mode;

  logic [1:0] stim_a, stim_o, stim_x;
  logic       busy_a, busy_o, busy_x;
  logic       done_a, done_o, done_x;
  logic       pass_a, pass_o, pass_x;
  logic [3:0] err_a, err_o, err_x;
  logic [1:0] ff_a, ff_o, ff_x;
  logic       y_a, y_o, y_x;
  logic       start_a, start_o, start_x;

  logic [1:0] obs_stim;
  logic       obs_busy, obs_done, obs_pass;
  logic [3:0] obs_err;
  logic [1:0] obs_ff;

  int total = 0;
  int bad   = 0;
  logic [1:0] stim_log [0:31];
  int done_idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign start_a = start && (sel == 0);
  assign start_o = start && (sel == 1);
  assign start_x = start && (sel == 2);

  assign y_a = (y_mode == 1) ? 1'b0 : (y_mode == 2) ? 1'b1 : (stim_a[0] & stim_a[1]);
  assign y_o = stim_o[0] & stim_o[1];
  assign y_x = stim_x[0] ^ stim_x[1];

  gate_bist_checker #(.N_IN(2), .TRUTH_TABLE(TT_AND), .SETTLE_CYCLES(1), .ERR_W(4)) u_and (
    .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .dut_y(y_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail(ff_a));

  gate_bist_checker #(.N_IN(2), .TRUTH_TABLE(TT_OR), .SETTLE_CYCLES(1), .ERR_W(4)) u_or (
    .clk(clk), .rst(rst), .start(start_o), .stim(stim_o), .dut_y(y_o), .busy(busy_o),
    .done(done_o), .pass(pass_o), .err_count(err_o), .first_fail(ff_o));

  gate_bist_checker #(.N_IN(2), .TRUTH_TABLE(TT_XOR), .SETTLE_CYCLES(0), .ERR_W(4)) u_xor (
    .clk(clk), .rst(rst), .start(start_x), .stim(stim_x), .dut_y(y_x), .busy(busy_x),
    .done(done_x), .pass(pass_x), .err_count(err_x), .first_fail(ff_x));

  always_comb begin
    obs_stim = stim_a; obs_busy = busy_a; obs_done = done_a;
    obs_pass = pass_a; obs_err = err_a;   obs_ff = ff_a;
    if (sel == 1) begin
      obs_stim = stim_o; obs_busy = busy_o; obs_done = done_o;
      obs_pass = pass_o; obs_err = err_o;   obs_ff = ff_o;
    end else if (sel == 2) begin
      obs_stim = stim_x; obs_busy = busy_x; obs_done = done_x;
      obs_pass = pass_x; obs_err = err_x;   obs_ff = ff_x;
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Start edge is the next rising edge; returns one cycle after it (index 0).
  task automatic start_run;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input int repulse_at, output int idx);
    idx = -1;
    for (int i = 0; i < limit; i++) begin
      stim_log[i] = obs_stim;
      if (obs_done) begin
        idx = i;
        break;
      end
      start = (i == repulse_at);
      step();
    end
    start = 1'b0;
  endtask

  task automatic check_idle_results(input string tag, input logic p, input logic [3:0] e, input logic [1:0] f);
    check({tag, "_pass"}, obs_pass, p);
    check({tag, "_err"},  obs_err,  e);
    check({tag, "_ff"},   obs_ff,   f);
  endtask

  initial begin
    logic [1:0] exp2 [0:7];
    bit saw_done;
    int guard;
    exp2[0] = 2'd0; exp2[1] = 2'd0; exp2[2] = 2'd1; exp2[3] = 2'd1;
    exp2[4] = 2'd2; exp2[5] = 2'd2; exp2[6] = 2'd3; exp2[7] = 2'd3;

    rst = 1'b1; start = 1'b0; sel = 0; y_mode = 0;
    #2;
    check("rst_stim", obs_stim, 2'd0);
    check("rst_busy", obs_busy, 1'b0);
    check("rst_done", obs_done, 1'b0);
    check_idle_results("rst", 1'b0, 4'd0, 2'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Correct AND gate
    start_run();
    check("and_busy", obs_busy, 1'b1);
    wait_done(20, -1, done_idx);
    check("and_done_idx", done_idx, 8);
    for (int i = 0; i < 8; i++) check($sformatf("and_stim%0d", i), stim_log[i], exp2[i]);
    check("and_busy_done", obs_busy, 1'b0);
    check_idle_results("and", 1'b1, 4'd0, 2'd0);
    step();
    check("and_done_pulse", obs_done, 1'b0);
    check("and_pass_hold", obs_pass, 1'b1);
    check("and_stim_idle", obs_stim, 2'd0);

    // Stuck-at-0 output against AND table
    y_mode = 1;
    start_run();
    check("sa0_pass_clr", obs_pass, 1'b0);
    wait_done(20, -1, done_idx);
    check("sa0_done_idx", done_idx, 8);
    check_idle_results("sa0", 1'b0, 4'd1, 2'd3);

    // Stuck-at-1 output
    step();
    y_mode = 2;
    start_run();
    wait_done(20, -1, done_idx);
    check("sa1_done_idx", done_idx, 8);
    check_idle_results("sa1", 1'b0, 4'd3, 2'd0);
    step(); step();
    check_idle_results("sa1_hold", 1'b0, 4'd3, 2'd0);

    // OR table against an AND gate
    sel = 1; y_mode = 0;
    start_run();
    wait_done(20, -1, done_idx);
    check("tt_done_idx", done_idx, 8);
    check_idle_results("tt", 1'b0, 4'd2, 2'd1);
    step();

    // Reset in the middle of a run
    sel = 0;
    start_run();
    guard = 0;
    while (obs_stim != 2'd2 && guard < 10) begin
      step();
      guard++;
    end
    check("mid_reached_stim2", obs_stim, 2'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_stim", obs_stim, 2'd0);
    check("mid_rst_busy", obs_busy, 1'b0);
    check("mid_rst_done", obs_done, 1'b0);
    check_idle_results("mid_rst", 1'b0, 4'd0, 2'd0);
    step();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (obs_done) saw_done = 1'b1;
      step();
    end
    check("mid_no_done", saw_done, 1'b0);
    start_run();
    wait_done(20, -1, done_idx);
    check("mid_rerun_idx", done_idx, 8);
    check_idle_results("mid_rerun", 1'b0 | 1'b1, 4'd0, 2'd0);
    step();

    // Start re-pulsed mid-run, then back-to-back start after done
    start_run();
    wait_done(20, 3, done_idx);
    check("busy_start_idx", done_idx, 8);
    check("busy_start_pass", obs_pass, 1'b1);
    step();
    check("b2b_idle_done", obs_done, 1'b0);
    start_run();
    check("b2b_busy", obs_busy, 1'b1);
    wait_done(20, -1, done_idx);
    check("b2b_done_idx", done_idx, 8);
    for (int i = 0; i < 8; i++) check($sformatf("b2b_stim%0d", i), stim_log[i], exp2[i]);
    check_idle_results("b2b", 1'b1, 4'd0, 2'd0);
    step();

    // XOR gate with zero settle cycles
    sel = 2;
    start_run();
    wait_done(20, -1, done_idx);
    check("xor_done_idx", done_idx, 4);
    for (int i = 0; i < 4; i++) check($sformatf("xor_stim%0d", i), stim_log[i], i[1:0]);
    check_idle_results("xor", 1'b1, 4'd0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
